// File: rtl/riscv_pkg.sv
// Shared RV32I constants: widths, bubble encoding, base opcodes and PC step.
// Imported by fetch, decode and the immediate generator.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_INC    = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [31:0] instr_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction memory port and IF/ID outputs.
// master = fetch stage side, slave = surrounding core / memory side.
interface if_stage_if
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
);
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  instr_t          imem_rdata;
  logic            imem_ready;
  logic [XLEN-1:0] pc_id;
  instr_t          instr_id;
  logic            valid_id;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata, imem_ready,
    output imem_addr, pc_id, instr_id, valid_id
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata, imem_ready,
    input  imem_addr, pc_id, instr_id, valid_id
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, hold freezes, otherwise loads the fetched word.
// One-cycle register; flush has priority over hold.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int          XLEN = riscv_pkg::XLEN,
  parameter logic [31:0] NOP  = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] pc_in,
  input  instr_t          instr_in,
  output logic [XLEN-1:0] pc_id,
  output instr_t          instr_id,
  output logic            valid_id
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc_id    <= '0;
      instr_id <= NOP;
      valid_id <= 1'b0;
    end else if (!hold) begin
      pc_id    <= pc_in;
      instr_id <= instr_in;
      valid_id <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV32I fetch stage: owns the PC, drives imem_addr combinationally from it, fills IF/ID.
// Fetch-to-decode latency 1 cycle; stall freezes everything, imem wait inserts bubbles.
module if_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master bus
);

  logic [XLEN-1:0] pc;
  logic            flush;

  // A wait state only bubbles IF/ID when the stage is not stalled.
  assign flush         = bus.redirect || (!bus.stall && !bus.imem_ready);
  assign bus.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (bus.redirect) begin
      pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (!bus.stall && bus.imem_ready) begin
      pc <= pc + XLEN'(PC_INC);
    end
  end

  if_id_reg #(
    .XLEN (XLEN),
    .NOP  (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .hold     (bus.stall),
    .pc_in    (pc),
    .instr_in (bus.imem_rdata),
    .pc_id    (bus.pc_id),
    .instr_id (bus.instr_id),
    .valid_id (bus.valid_id)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios against hand-derived constants, then random
// traffic against a cycle-level reference model of the fetch rules.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_pc_id, m_instr;
  logic        m_valid;

  if_stage_if #(.XLEN(32)) bus();

  if_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [96:0] obs();
    return {bus.imem_addr, bus.pc_id, bus.instr_id, bus.valid_id};
  endfunction

  function automatic logic [96:0] mdl();
    return {m_pc, m_pc_id, m_instr, m_valid};
  endfunction

  // Drive one cycle of inputs, clock it, then advance the model by the fetch rules.
  task automatic step(input logic rst, input logic s, input logic r, input logic [31:0] rpc,
                      input logic rdy, input logic [31:0] rd);
    reset           = rst;
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.imem_ready  = rdy;
    bus.imem_rdata  = rd;
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 32'h0; m_pc_id = 32'h0; m_instr = NOP; m_valid = 1'b0;
    end else if (r) begin
      m_pc = rpc & 32'hFFFF_FFFC; m_pc_id = 32'h0; m_instr = NOP; m_valid = 1'b0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (!rdy) begin
      m_pc_id = 32'h0; m_instr = NOP; m_valid = 1'b0;
    end else begin
      m_pc_id = m_pc; m_instr = rd; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    logic [96:0] got;
    step(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    step(1, 1, 1, 32'h0000_0400, 1, 32'hDEAD_BEEF);
    got = obs(); n_checks++;
    if (got !== {32'h0, 32'h0, NOP, 1'b0}) begin
      n_fail++; $display("FAIL reset_state: got %h required %h", got, {32'h0, 32'h0, NOP, 1'b0});
    end
  endtask

  task automatic test_fetch();
    logic [96:0] got;
    logic [31:0] words [3];
    words[0] = 32'h0050_0093; words[1] = 32'h00A0_0113; words[2] = 32'h0020_81B3;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, words[i]);
      got = obs(); n_checks++;
      if (got !== {32'(4 * (i + 1)), 32'(4 * i), words[i], 1'b1}) begin
        n_fail++;
        $display("FAIL fetch_%0d: got %h required %h", i, got, {32'(4 * (i + 1)), 32'(4 * i), words[i], 1'b1});
      end
    end
  endtask

  task automatic test_stall();
    logic [96:0] got;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0050_0093);
    step(0, 0, 0, 0, 1, 32'h00A0_0113);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 1'($urandom), $urandom);
      got = obs(); n_checks++;
      if (got !== {32'h8, 32'h4, 32'h00A0_0113, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold_%0d: got %h required %h", i, got, {32'h8, 32'h4, 32'h00A0_0113, 1'b1});
      end
    end
    step(0, 0, 0, 0, 1, 32'h0020_81B3);
    got = obs(); n_checks++;
    if (got !== {32'hC, 32'h8, 32'h0020_81B3, 1'b1}) begin
      n_fail++; $display("FAIL stall_release: got %h required %h", got, {32'hC, 32'h8, 32'h0020_81B3, 1'b1});
    end
  endtask

  task automatic test_redirect_stall();
    logic [96:0] got;
    // Redirect/stall must not reach any output before the clock edge.
    bus.stall = 1; bus.redirect = 1; bus.redirect_pc = 32'h0000_0103;
    #1;
    got = obs(); n_checks++;
    if (got !== {32'hC, 32'h8, 32'h0020_81B3, 1'b1}) begin
      n_fail++; $display("FAIL redirect_no_comb: got %h required %h", got, {32'hC, 32'h8, 32'h0020_81B3, 1'b1});
    end
    step(0, 1, 1, 32'h0000_0103, 1, 32'h1111_1111);
    got = obs(); n_checks++;
    if (got !== {32'h100, 32'h0, NOP, 1'b0}) begin
      n_fail++; $display("FAIL redirect_flush: got %h required %h", got, {32'h100, 32'h0, NOP, 1'b0});
    end
    step(0, 0, 0, 0, 1, 32'h0000_A0B7);
    got = obs(); n_checks++;
    if (got !== {32'h104, 32'h100, 32'h0000_A0B7, 1'b1}) begin
      n_fail++; $display("FAIL redirect_refetch: got %h required %h", got, {32'h104, 32'h100, 32'h0000_A0B7, 1'b1});
    end
  endtask

  task automatic test_imem_wait();
    logic [96:0] got;
    step(0, 0, 1, 32'h0000_001C, 1, 0);
    step(0, 0, 0, 0, 1, 32'h0030_0193);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, $urandom);
      got = obs(); n_checks++;
      if (got !== {32'h20, 32'h0, NOP, 1'b0}) begin
        n_fail++; $display("FAIL wait_bubble_%0d: got %h required %h", i, got, {32'h20, 32'h0, NOP, 1'b0});
      end
    end
    step(0, 0, 0, 0, 1, 32'h0040_0213);
    got = obs(); n_checks++;
    if (got !== {32'h24, 32'h20, 32'h0040_0213, 1'b1}) begin
      n_fail++; $display("FAIL wait_resume: got %h required %h", got, {32'h24, 32'h20, 32'h0040_0213, 1'b1});
    end
  endtask

  task automatic test_wrap();
    logic [96:0] got;
    step(0, 0, 1, 32'hFFFF_FFFE, 1, 0);
    got = obs(); n_checks++;
    if (got !== {32'hFFFF_FFFC, 32'h0, NOP, 1'b0}) begin
      n_fail++; $display("FAIL wrap_redirect: got %h required %h", got, {32'hFFFF_FFFC, 32'h0, NOP, 1'b0});
    end
    step(0, 0, 0, 0, 1, 32'h0000_0063);
    got = obs(); n_checks++;
    if (got !== {32'h0, 32'hFFFF_FFFC, 32'h0000_0063, 1'b1}) begin
      n_fail++; $display("FAIL wrap_fetch: got %h required %h", got, {32'h0, 32'hFFFF_FFFC, 32'h0000_0063, 1'b1});
    end
  endtask

  task automatic test_reset_in_stall();
    logic [96:0] got;
    step(0, 0, 1, 32'h0000_003C, 1, 0);
    step(0, 0, 0, 0, 1, 32'h0000_0513);
    step(0, 1, 0, 0, 1, 0);
    got = obs(); n_checks++;
    if (got !== {32'h40, 32'h3C, 32'h0000_0513, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset_stall: got %h required %h", got, {32'h40, 32'h3C, 32'h0000_0513, 1'b1});
    end
    step(1, 1, 0, 0, 1, 32'h1234_5678);
    got = obs(); n_checks++;
    if (got !== {32'h0, 32'h0, NOP, 1'b0}) begin
      n_fail++; $display("FAIL reset_in_stall: got %h required %h", got, {32'h0, 32'h0, NOP, 1'b0});
    end
  endtask

  task automatic test_random();
    logic        s, r, rdy, rst;
    logic [31:0] rpc, rd;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      r   = ($urandom_range(0, 99) < 10);
      s   = ($urandom_range(0, 99) < 20);
      rdy = ($urandom_range(0, 99) < 75);
      rpc = (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : 32'h0) | $urandom_range(0, 32'h3FF);
      rd  = $urandom;
      n_checks++;
      if (bus.imem_addr !== m_pc) begin
        n_fail++; $display("FAIL rand_addr_%0d: got %h required %h", i, bus.imem_addr, m_pc);
      end
      step(rst, s, r, rpc, rdy, rd);
      n_checks++;
      if (obs() !== mdl()) begin
        n_fail++; $display("FAIL rand_state_%0d: got %h required %h", i, obs(), mdl());
      end
    end
  endtask

  initial begin
    reset = 1; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    bus.imem_ready = 0; bus.imem_rdata = '0;
    m_pc = 0; m_pc_id = 0; m_instr = NOP; m_valid = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_stall();
    test_imem_wait();
    test_wrap();
    test_reset_in_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage of the pipelined RV32I core. It owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. The registered instruction feeds the decode stage: the immediate generator, register file and control. The stage handles hazard-unit stalls, EX-stage branch redirects, and instruction-memory wait states.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID contents
redirect  in  1  EX stage: branch/jump taken, flush and refetch
redirect_pc  in  XLEN  target address for redirect
imem_addr  out  XLEN  instruction memory address (= current PC, combinational from PC reg)
imem_rdata  in  32  instruction word for imem_addr, valid when imem_ready=1
imem_ready  in  1  instruction memory has valid data this cycle
pc_id  out  XLEN  PC of instruction held in IF/ID
instr_id  out  32  instruction held in IF/ID (input to decode / immediate generation)
valid_id  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- PC register and IF/ID register update only on posedge clk. imem_addr = pc, with no added latency.
- Priority per cycle: reset > redirect > stall > !imem_ready > normal fetch.
- reset=1: pc<=RESET_PC; instr_id<=NOP_INSTR; pc_id<=0; valid_id<=0. Reset mid-stall or mid-redirect wins unconditionally.
- redirect=1: pc<={redirect_pc[XLEN-1:2],2'b00} (low bits forced to zero, no misalign trap); instr_id<=NOP_INSTR; valid_id<=0; pc_id<=0. Redirect overrides a simultaneous stall.
- stall=1 (no redirect): pc, pc_id, instr_id and valid_id all hold. imem_ready is ignored.
- imem_ready=0 (no stall/redirect): pc holds; IF/ID loads a bubble (NOP_INSTR, valid_id=0, pc_id=0).
- Normal fetch: pc<=pc+4 (modulo 2^XLEN; 0xFFFF_FFFC wraps to 0); instr_id<=imem_rdata; pc_id<=pc; valid_id<=1.
- Fetch-to-decode latency is 1 cycle: the word at PC p appears on instr_id the cycle after the fetch of p is accepted.
- Outputs are never X after the first reset edge. No combinational path from stall or redirect to any output.
- Effective FSM, implicit in valid_id:
  - BUBBLE (valid_id=0): exited by a normal fetch.
  - VALID (valid_id=1): returns to BUBBLE on redirect or imem wait.
  - Stall freezes the current state.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and NOP_INSTR constants.
  - Opcode localparams (OP_LOAD 7'b0000011, OP_IMM 7'b0010011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011), shared with decode and the immediate generator.
  - The PC increment constant 4.
- One sub-module is natural: if_id_reg, the IF/ID register with hold/flush/load controls. PC logic stays in if_stage.

Test Plan:
- Reset then 3 cycles of imem_ready=1, rdata 0x00500093, 0x00A00113, 0x002081B3 → imem_addr 0,4,8,12; instr_id 0x00500093 with pc_id 0 and valid_id 1 on cycle 2.
- stall=1 for 2 cycles at pc=8 → imem_addr stays 8; instr_id/pc_id/valid_id frozen; on release, fetch resumes at 8 then 12.
- redirect=1, redirect_pc=0x0000_0103, simultaneous stall=1 → next cycle pc=0x100, instr_id=0x00000013, valid_id=0; the following cycle fetches 0x100.
- imem_ready=0 for 3 cycles at pc=0x20 → pc holds 0x20; valid_id=0 with NOP each cycle; ready=1 then gives pc_id=0x20, valid_id=1.
- Force pc=0xFFFF_FFFC via redirect, then normal fetch → imem_addr wraps to 0x0000_0000; pc_id=0xFFFF_FFFC.
- Assert reset during stall with pc=0x40 → next cycle pc=RESET_PC, valid_id=0, instr_id=NOP_INSTR.
